// File: rtl/uart_pkg.sv
// Shared UART types and constants: trigger-level encoding, receive timeout
// FSM states, timeout length, interrupt bit positions and a trigger helper.
package uart_pkg;

  typedef enum logic [1:0] {
    UART_TRIG_ONE       = 2'b00,
    UART_TRIG_QUARTER   = 2'b01,
    UART_TRIG_HALF      = 2'b10,
    UART_TRIG_NEAR_FULL = 2'b11
  } uart_trig_e;

  typedef enum logic [1:0] {
    TO_IDLE  = 2'b00,
    TO_COUNT = 2'b01,
    TO_FIRED = 2'b10
  } uart_to_state_e;

  localparam int unsigned UART_TO_CHARS      = 4;
  localparam int unsigned UART_BITS_PER_CHAR = 10;
  localparam int unsigned UART_TO_TICKS      = UART_TO_CHARS * UART_BITS_PER_CHAR;

  localparam int unsigned IRQ_LEVEL   = 0;
  localparam int unsigned IRQ_OVERRUN = 1;
  localparam int unsigned IRQ_TIMEOUT = 2;
  localparam int unsigned IRQ_PARITY  = 3;

  // FIFO occupancy at which the level interrupt source asserts
  function automatic int unsigned uart_trig_level(input uart_trig_e trig,
                                                  input int unsigned depth);
    case (trig)
      UART_TRIG_ONE:     return 1;
      UART_TRIG_QUARTER: return depth / 4;
      UART_TRIG_HALF:    return depth / 2;
      default:           return depth - 2;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO shared by the UART RX and TX paths.
// Ports: clk_i/rst_i (async active-high), clr_i flush (beats push/pop),
// push_i/data_i write side, pop_i read side, data_o head (0 when empty),
// level_o occupancy, full_o, empty_o.
module uart_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = empty_o ? '0 : mem[rd_ptr_q];

  // A pop frees the slot a same-cycle push into a full FIFO needs
  assign do_pop  = pop_i & ~empty_o & ~clr_i;
  assign do_push = push_i & (~full_o | do_pop) & ~clr_i;

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array, no reset needed since reads are masked while empty
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: buffers characters from uart_rx in a FWFT FIFO,
// tracks sticky overrun/parity flags, optional character timeout, and a
// masked registered interrupt.
// Ports: clk_i/rst_i (async active-high); cfg_* enable/divider/trigger;
// irq_en_i mask [0]level [1]overrun [2]timeout [3]parity; fifo_clr_i,
// status_clr_i; rx_* handshake with uart_rx; rd_* FIFO head for APB;
// level_o, overrun_o, timeout_o, parity_err_o, irq_o status.
// Build option: define UART_RX_CTRL_TIMEOUT_EN to include the timeout
// detector; otherwise timeout_o is tied low.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cfg_en_i,
  input  logic [15:0]                   cfg_div_i,
  input  logic [1:0]                    cfg_trig_i,
  input  logic [3:0]                    irq_en_i,
  input  logic                          fifo_clr_i,
  input  logic                          status_clr_i,
  input  logic [DATA_WIDTH-1:0]         rx_data_i,
  input  logic                          rx_valid_i,
  output logic                          rx_ready_o,
  input  logic                          rx_busy_i,
  input  logic                          rx_err_i,
  output logic                          rx_err_clr_o,
  input  logic                          rd_req_i,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic                          rd_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overrun_o,
  output logic                          timeout_o,
  output logic                          parity_err_o,
  output logic                          irq_o
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic          en_q, overrun_q, parity_q, err_clr_q, irq_q;
  logic          flush, push_req, pop_req, full, empty, irq_d;
  logic [LW-1:0] trig_lvl;

  // Receiver is never stalled; excess characters are dropped as overrun
  assign rx_ready_o = cfg_en_i;
  assign push_req   = rx_valid_i & cfg_en_i;
  assign pop_req    = rd_req_i & ~empty;
  assign flush      = fifo_clr_i | (en_q & ~cfg_en_i);
  assign trig_lvl   = LW'(uart_trig_level(uart_trig_e'(cfg_trig_i), FIFO_DEPTH));

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (flush),
    .push_i  (push_req),
    .data_i  (rx_data_i),
    .pop_i   (pop_req),
    .data_o  (rd_data_o),
    .level_o (level_o),
    .full_o  (full),
    .empty_o (empty)
  );

  assign rd_valid_o   = ~empty;
  assign overrun_o    = overrun_q;
  assign parity_err_o = parity_q;
  assign rx_err_clr_o = err_clr_q;
  assign irq_o        = irq_q;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  uart_to_state_e to_state_q, to_state_d;
  logic [15:0]    presc_q, presc_d;
  logic [5:0]     ticks_q, ticks_d;
  logic           to_fire, to_q, activity, tick;

  assign activity  = push_req | pop_req | flush | rx_busy_i;
  assign tick      = (presc_q == cfg_div_i);
  assign timeout_o = to_q;

  // Timeout state and counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_state_q <= TO_IDLE;
      presc_q    <= '0;
      ticks_q    <= '0;
    end else begin
      to_state_q <= to_state_d;
      presc_q    <= presc_d;
      ticks_q    <= ticks_d;
    end
  end

  // Timeout next-state: any line or FIFO activity restarts the silence count
  always_comb begin
    to_state_d = to_state_q;
    presc_d    = presc_q;
    ticks_d    = ticks_q;
    to_fire    = 1'b0;
    if (activity) begin
      to_state_d = TO_IDLE;
      presc_d    = '0;
      ticks_d    = '0;
    end else begin
      case (to_state_q)
        TO_IDLE: begin
          if (!empty) begin
            to_state_d = TO_COUNT;
            presc_d    = '0;
            ticks_d    = '0;
          end
        end
        TO_COUNT: begin
          if (tick) begin
            presc_d = '0;
            if (ticks_q == 6'(UART_TO_TICKS - 1)) begin
              to_state_d = TO_FIRED;
              ticks_d    = '0;
              to_fire    = 1'b1;
            end else begin
              ticks_d = ticks_q + 6'(1);
            end
          end else begin
            presc_d = presc_q + 16'(1);
          end
        end
        TO_FIRED: begin
          if (status_clr_i) to_state_d = TO_IDLE;
        end
        default: to_state_d = TO_IDLE;
      endcase
    end
  end

  // Timeout flag: firing wins over a same-cycle clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)             to_q <= 1'b0;
    else if (to_fire)      to_q <= 1'b1;
    else if (status_clr_i) to_q <= 1'b0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^{cfg_div_i, rx_busy_i, irq_en_i[IRQ_TIMEOUT]};
  assign timeout_o      = 1'b0;
`endif

  // Interrupt sources, masked; registered below
  always_comb begin
    irq_d = (irq_en_i[IRQ_LEVEL]   & (level_o >= trig_lvl))
          | (irq_en_i[IRQ_OVERRUN] & overrun_q)
          | (irq_en_i[IRQ_PARITY]  & parity_q);
`ifdef UART_RX_CTRL_TIMEOUT_EN
    irq_d = irq_d | (irq_en_i[IRQ_TIMEOUT] & to_q);
`endif
  end

  // Sticky flags (set beats clear), error-clear pulse, irq and enable history
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q      <= 1'b0;
      overrun_q <= 1'b0;
      parity_q  <= 1'b0;
      err_clr_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= cfg_en_i;
      err_clr_q <= status_clr_i;
      irq_q     <= irq_d;
      if (push_req & full & ~rd_req_i & ~flush) overrun_q <= 1'b1;
      else if (status_clr_i)                    overrun_q <= 1'b0;
      if (rx_err_i)          parity_q <= 1'b1;
      else if (status_clr_i) parity_q <= 1'b0;
    end
  end

endmodule
